// File: rtl/pc_fetch_seq.sv
// Fetch sequencer: owns the program counter, issues instruction-memory
// requests and hands each fetched word, tagged with its PC, to decode over a
// valid/ready handshake. A redirect reloads the PC and flushes the buffered
// instruction.
module pc_fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        ena,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic [31:0] pc_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] data_r;
    logic [31:0] ipc_r;
    logic        req_r;
    logic        valid_r;

    // Word-align a PC by clearing its byte-offset bits.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

    // Next sequential PC; wraps modulo 2^32 with no flag.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // The target's byte-offset bits are deliberately discarded.
    logic unused_offset_s;
    assign unused_offset_s = ^redirect_pc[1:0];

    // Sequencer FSM: PC, request strobe and decode buffer all update here.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_r <= IDLE;
            pc_r    <= RESET_PC;
            data_r  <= 32'd0;
            ipc_r   <= 32'd0;
            req_r   <= 1'b0;
            valid_r <= 1'b0;
        end else if (redirect) begin
            // Redirect wins over ack and handshake. An abandoned request
            // re-enters through IDLE so the request strobe drops for a cycle.
            pc_r    <= align_pc(redirect_pc);
            valid_r <= 1'b0;
            if ((state_r == REQ) || !ena) begin
                state_r <= IDLE;
                req_r   <= 1'b0;
            end else begin
                state_r <= REQ;
                req_r   <= 1'b1;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (ena) begin
                        state_r <= REQ;
                        req_r   <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        req_r   <= 1'b0;
                    end
                end
                REQ: begin
                    // ena is not consulted: an issued request always completes.
                    if (imem_ack) begin
                        data_r  <= imem_rdata;
                        ipc_r   <= pc_r;
                        valid_r <= 1'b1;
                        pc_r    <= next_pc(pc_r);
                        state_r <= HOLD;
                        req_r   <= 1'b0;
                    end else begin
                        state_r <= REQ;
                        req_r   <= 1'b1;
                    end
                end
                HOLD: begin
                    if (valid_r && inst_ready) begin
                        valid_r <= 1'b0;
                        if (ena) begin
                            state_r <= REQ;
                            req_r   <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            req_r   <= 1'b0;
                        end
                    end else begin
                        state_r <= HOLD;
                        req_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req   = req_r;
    assign imem_addr  = pc_r;
    assign pc_out     = pc_r;
    assign inst_valid = valid_r;
    assign inst_data  = data_r;
    assign inst_pc    = ipc_r;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Bench for pc_fetch_seq: a memory responder with programmable ack latency,
// a PC model plus scoreboard of {pc, word} pairs checked at each handshake,
// and directed checks for stalls, redirects, wraparound and async reset.
module tb_pc_fetch_seq;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        ena = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic [31:0] pc_out;

    int          total = 0;
    int          bad = 0;
    int          ack_delay = 1;
    int          wait_cnt = 0;
    logic [31:0] model_pc = RESET_PC;
    logic [63:0] sb[$];

    pc_fetch_seq #(.RESET_PC(RESET_PC)) dut (
        .CLK(CLK), .RST_n(RST_n), .ena(ena), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
        .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .pc_out(pc_out)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        int n = 0;
        while (!inst_valid && n < max_cycles) begin
            tick();
            n++;
        end
        check_eq(tag, {31'd0, inst_valid}, 32'd1);
    endtask

    task automatic do_reset();
        ena         = 1'b0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        RST_n       = 1'b0;
        repeat (2) tick();
        RST_n = 1'b1;
    endtask

    // Memory responder: acks after ack_delay cycles of an active request.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            imem_rdata = $urandom;
            if (RST_n && imem_req) begin
                wait_cnt++;
                imem_ack = (wait_cnt >= ack_delay);
                if (imem_ack) wait_cnt = 0;
            end else begin
                wait_cnt = 0;
                imem_ack = 1'b0;
            end
        end
    end

    // PC model and scoreboard, evaluated mid-cycle on stable signals.
    always @(negedge CLK) begin
        if (!RST_n) begin
            model_pc = RESET_PC;
            sb.delete();
        end else begin
            if (imem_req) check_eq("imem_addr", imem_addr, model_pc);
            if (redirect) begin
                model_pc = {redirect_pc[31:2], 2'b00};
                sb.delete();
            end else begin
                if (imem_req && imem_ack) begin
                    sb.push_back({model_pc, imem_rdata});
                    model_pc = model_pc + 32'd4;
                end
                if (inst_valid && inst_ready) begin
                    if (sb.size() == 0) begin
                        check_eq("sb_underflow", 32'(sb.size()), 32'd1);
                    end else begin
                        logic [63:0] e;
                        e = sb.pop_front();
                        check_eq("sb_pc", inst_pc, e[63:32]);
                        check_eq("sb_data", inst_data, e[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        // Reset state
        RST_n = 1'b0;
        repeat (2) tick();
        check_eq("rst_req", {31'd0, imem_req}, 32'd0);
        check_eq("rst_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("rst_data", inst_data, 32'd0);
        check_eq("rst_ipc", inst_pc, 32'd0);
        check_eq("rst_pc", pc_out, RESET_PC);
        check_eq("rst_addr", imem_addr, RESET_PC);
        RST_n = 1'b1;

        // Streaming with 1-cycle ack and ready held high
        ena = 1'b1;
        inst_ready = 1'b1;
        ack_delay = 1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_eq("stream_valid", {31'd0, inst_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i % 2 == 0)
                check_eq("stream_pc", inst_pc, RESET_PC + 32'(4 * (i / 2 - 1)));
        end

        // Ack delayed 3 cycles, decode stalled afterwards
        do_reset();
        ena = 1'b1;
        inst_ready = 1'b0;
        ack_delay = 3;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_eq("slow_req", {31'd0, imem_req}, 32'd1);
            check_eq("slow_addr", imem_addr, RESET_PC);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("stall_valid", {31'd0, inst_valid}, 32'd1);
            check_eq("stall_ipc", inst_pc, RESET_PC);
            if (sb.size() != 0) check_eq("stall_data", inst_data, sb[0][31:0]);
            check_eq("stall_req", {31'd0, imem_req}, 32'd0);
            check_eq("stall_pc", pc_out, 32'h0040_0004);
        end

        // Redirect during HOLD flushes the buffer, fetch resumes aligned
        redirect = 1'b1;
        redirect_pc = 32'h0040_0103;
        tick();
        redirect = 1'b0;
        check_eq("rdh_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("rdh_req", {31'd0, imem_req}, 32'd1);
        check_eq("rdh_addr", imem_addr, 32'h0040_0100);
        inst_ready = 1'b1;
        wait_valid("rdh_wait", 10);
        check_eq("rdh_ipc", inst_pc, 32'h0040_0100);

        // Redirect coincident with ack in REQ: ack is discarded
        do_reset();
        ena = 1'b1;
        inst_ready = 1'b0;
        ack_delay = 1;
        tick();
        check_eq("rdq_req1", {31'd0, imem_req}, 32'd1);
        redirect = 1'b1;
        redirect_pc = 32'h0040_0200;
        tick();
        redirect = 1'b0;
        check_eq("rdq_drop", {31'd0, imem_req}, 32'd0);
        check_eq("rdq_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("rdq_pc", pc_out, 32'h0040_0200);
        tick();
        check_eq("rdq_req2", {31'd0, imem_req}, 32'd1);
        tick();
        check_eq("rdq_valid2", {31'd0, inst_valid}, 32'd1);
        check_eq("rdq_ipc", inst_pc, 32'h0040_0200);
        if (sb.size() != 0) check_eq("rdq_data", inst_data, sb[0][31:0]);

        // Wraparound at the top of the address space; ena drop mid-REQ
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        ack_delay = 2;
        tick();
        redirect = 1'b0;
        ena = 1'b0;
        check_eq("wrap_req", {31'd0, imem_req}, 32'd1);
        check_eq("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        check_eq("wrap_noabort", {31'd0, imem_req}, 32'd1);
        tick();
        check_eq("wrap_pc", pc_out, 32'h0000_0000);
        check_eq("wrap_valid", {31'd0, inst_valid}, 32'd1);
        check_eq("wrap_ipc", inst_pc, 32'hFFFF_FFFC);
        inst_ready = 1'b1;
        tick();
        check_eq("idle_req", {31'd0, imem_req}, 32'd0);
        check_eq("idle_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        check_eq("idle_stay", {31'd0, imem_req}, 32'd0);

        // Asynchronous reset in the middle of a request
        ena = 1'b1;
        ack_delay = 5;
        tick();
        check_eq("arst_pre_req", {31'd0, imem_req}, 32'd1);
        #2;
        RST_n = 1'b0;
        #1;
        check_eq("arst_req", {31'd0, imem_req}, 32'd0);
        check_eq("arst_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("arst_pc", pc_out, RESET_PC);
        ena = 1'b0;
        repeat (2) tick();
        RST_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
